// File: rtl/alu_multicycle_if.sv
// Handshake and data bundle for alu_multicycle: operation request in,
// registered result, flags and completion pulse out.
interface alu_multicycle_if;
  logic        start;
  logic [3:0]  alu_ctrl;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] result;
  logic        zero;
  logic        busy;
  logic        done;
  logic        illegal;

  modport master (
    output start, alu_ctrl, a, b,
    input  result, zero, busy, done, illegal
  );

  modport slave (
    input  start, alu_ctrl, a, b,
    output result, zero, busy, done, illegal
  );
endinterface

// File: rtl/alu_multicycle.sv
// Small ALU: AND/OR/ADD/SUB complete in one cycle, MUL is an iterative
// shift-add over 32 cycles (one multiplier bit per cycle, LSB first).
module alu_multicycle (
  input  logic              clk,
  input  logic              reset,
  alu_multicycle_if.slave   bus
);

  typedef enum logic {IDLE, MUL} state_t;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0011,
    OP_MUL = 4'b0100
  } op_t;

  state_t      state, state_n;
  logic [5:0]  cnt, cnt_n;
  logic [31:0] acc, acc_n;
  logic [31:0] mcand, mcand_n;
  logic [31:0] mplier, mplier_n;
  logic [31:0] result_q, result_n;
  logic        zero_q, zero_n;
  logic        done_q, done_n;
  logic        ill_q, ill_n;
  logic [31:0] step;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      acc      <= acc_n;
      mcand    <= mcand_n;
      mplier   <= mplier_n;
      result_q <= result_n;
      zero_q   <= zero_n;
      done_q   <= done_n;
      ill_q    <= ill_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    acc_n    = acc;
    mcand_n  = mcand;
    mplier_n = mplier;
    result_n = result_q;
    zero_n   = zero_q;
    done_n   = 1'b0;
    ill_n    = 1'b0;
    step     = acc + (mplier[0] ? mcand : '0);

    case (state)
      IDLE: begin
        if (bus.start) begin
          case (bus.alu_ctrl)
            OP_AND: begin result_n = bus.a & bus.b; done_n = 1'b1; end
            OP_OR:  begin result_n = bus.a | bus.b; done_n = 1'b1; end
            OP_ADD: begin result_n = bus.a + bus.b; done_n = 1'b1; end
            OP_SUB: begin result_n = bus.a - bus.b; done_n = 1'b1; end
            OP_MUL: begin
              state_n  = MUL;
              cnt_n    = '0;
              acc_n    = '0;
              mcand_n  = bus.a;
              mplier_n = bus.b;
            end
            default: begin
              result_n = '0;
              done_n   = 1'b1;
              ill_n    = 1'b1;
            end
          endcase
        end
      end
      MUL: begin
        acc_n    = step;
        mcand_n  = mcand << 1;
        mplier_n = mplier >> 1;
        cnt_n    = cnt + 6'd1;
        // Last bit is folded into the result directly so result lands on E32.
        if (cnt == 6'd31) begin
          state_n  = IDLE;
          result_n = step;
          done_n   = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // zero tracks result only when an operation completes; it holds otherwise.
    if (done_n) zero_n = (result_n == '0);
  end

  assign bus.result  = result_q;
  assign bus.zero    = zero_q;
  assign bus.busy    = (state == MUL);
  assign bus.done    = done_q;
  assign bus.illegal = ill_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Randomized scoreboard bench for alu_multicycle: driver queues expected
// completions, a negedge monitor checks every cycle against them.
module tb_alu_multicycle;

  logic clk;
  logic reset;
  int   cyc;
  logic rst_q;

  alu_multicycle_if bus ();

  alu_multicycle dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        ill;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          vectors;
  int          miscompares;
  logic [31:0] last_res;
  logic        last_z;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model: straight arithmetic on the architectural operation.
  function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    case (op)
      4'd0:    return x & y;
      4'd1:    return x | y;
      4'd2:    return x + y;
      4'd3:    return x - y;
      4'd4:    return x * y;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
  endtask

  task automatic do_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    exp_t ent;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.alu_ctrl = op;
    bus.a        = x;
    bus.b        = y;
    ent.res = ref_result(op, x, y);
    ent.z   = (ent.res == 32'd0);
    ent.ill = (op > 4'd4);
    ent.cyc = cyc + 1 + ((op == 4'd4) ? 32 : 0);
    q.push_back(ent);
    if (op == 4'd4) begin
      for (int i = 0; i < 32; i++) begin
        @(negedge clk);
        chk("busy_mul", {31'd0, bus.busy}, 32'd1);
        bus.start    = 1'($urandom_range(0, 1));
        bus.alu_ctrl = 4'($urandom);
        bus.a        = $urandom;
        bus.b        = $urandom;
      end
    end
  endtask

  task automatic abort_mul();
    @(negedge clk);
    bus.start    = 1'b1;
    bus.alu_ctrl = 4'd4;
    bus.a        = 32'h1234_5678;
    bus.b        = 32'h0000_0003;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      chk("busy_abort", {31'd0, bus.busy}, 32'd1);
    end
    @(negedge clk);
    reset = 1'b1;
    q.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic reset_with_start();
    @(negedge clk);
    reset        = 1'b1;
    bus.start    = 1'b1;
    bus.alu_ctrl = 4'd2;
    bus.a        = 32'd1;
    bus.b        = 32'd1;
    q.delete();
    @(negedge clk);
    reset     = 1'b0;
    bus.start = 1'b0;
  endtask

  // Monitor: every cycle is either reset, a completion, or a hold cycle.
  always @(negedge clk) begin
    if (cyc > 0) begin
      if (rst_q) begin
        chk("rst_result", bus.result, 32'd0);
        chk("rst_zero", {31'd0, bus.zero}, 32'd1);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_illegal", {31'd0, bus.illegal}, 32'd0);
        last_res = 32'd0;
        last_z   = 1'b1;
      end else if (bus.done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", {31'd0, bus.done}, 32'd0);
        end else begin
          e = q.pop_front();
          chk("result", bus.result, e.res);
          chk("zero", {31'd0, bus.zero}, {31'd0, e.z});
          chk("illegal", {31'd0, bus.illegal}, {31'd0, e.ill});
          chk("done_cycle", cyc, e.cyc);
          chk("busy_at_done", {31'd0, bus.busy}, 32'd0);
          last_res = e.res;
          last_z   = e.z;
        end
      end else begin
        chk("hold_result", bus.result, last_res);
        chk("hold_zero", {31'd0, bus.zero}, {31'd0, last_z});
        chk("illegal_without_done", {31'd0, bus.illegal}, 32'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    logic [3:0] op;
    vectors      = 0;
    miscompares  = 0;
    last_res     = 32'd0;
    last_z       = 1'b1;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.alu_ctrl = 4'd0;
    bus.a        = 32'd0;
    bus.b        = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    do_op(4'd2, 32'hFFFF_FFFF, 32'd1);
    idle(1);
    do_op(4'd3, 32'h1234, 32'h1234);
    do_op(4'd3, 32'd5, 32'd7);
    idle(1);
    do_op(4'd4, 32'h0001_0001, 32'h0001_0001);
    idle(1);
    do_op(4'd0, 32'hF0F0_F0F0, 32'hFF00_FF00);
    idle(1);
    do_op(4'd1, 32'hF0F0_F0F0, 32'hFF00_FF00);
    idle(1);
    do_op(4'd7, 32'hDEAD_BEEF, 32'h1);
    idle(2);
    abort_mul();
    idle(3);
    do_op(4'd2, 32'd3, 32'd4);
    idle(1);
    reset_with_start();
    idle(2);
    do_op(4'd4, 32'd0, 32'd5);
    do_op(4'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op(4'd2, 32'd9, 32'd1);
    idle(1);

    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 99);
      if (r < 15)      op = 4'd4;
      else if (r < 22) op = 4'($urandom_range(5, 15));
      else             op = 4'($urandom_range(0, 3));
      do_op(op, rand_opnd(), rand_opnd());
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end

    idle(40);
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL pending_ops: got %0d outstanding expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
